// File: rtl/ultra_sonic_ranger.sv
// rtl/ultra_sonic_ranger.sv - HC-SR04-style trig/echo range controller; optional 4-sample mean via ULTRA_SONIC_AVG_EN
module ultra_sonic_ranger #(
    parameter int unsigned TRIG_CYCLES    = 500,
    parameter int unsigned PERIOD_CYCLES  = 3000000,
    parameter int unsigned TIMEOUT_CYCLES = 1500000,
    parameter int unsigned CYCLES_PER_CM  = 2900,
    parameter int unsigned DIST_W         = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              echo,
    output logic              trig,
    output logic [DIST_W-1:0] distance_out,
    output logic              valid,
    output logic              timeout,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT_RISE,
        S_MEASURE,
        S_REPORT,
        S_HOLDOFF
    } state_t;

    localparam logic [DIST_W-1:0] CM_MAX = {DIST_W{1'b1}} - DIST_W'(1);

    state_t            r_state;
    state_t            w_state_next;

    logic              r_echo_s1;
    logic              r_echo_s2;
    logic              r_echo_d;
    logic              r_rise;
    logic              r_fall;

    logic [31:0]       r_period;
    logic [31:0]       r_cnt;
    logic [31:0]       r_presc;
    logic [DIST_W-1:0] r_cm;
    logic [DIST_W-1:0] r_dist;
    logic              r_to;

    logic              w_report_ok;
    logic              w_report_to;
    logic [DIST_W-1:0] w_sample;

    // Echo synchroniser followed by registered edge pulses (sync value vs. its 1-cycle delay)
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_echo_s1 <= 1'b0;
            r_echo_s2 <= 1'b0;
            r_echo_d  <= 1'b0;
            r_rise    <= 1'b0;
            r_fall    <= 1'b0;
        end else begin
            r_echo_s1 <= echo;
            r_echo_s2 <= r_echo_s1;
            r_echo_d  <= r_echo_s2;
            r_rise    <= r_echo_s2 & ~r_echo_d;
            r_fall    <= ~r_echo_s2 & r_echo_d;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; edge pulses are only looked at in the states that care about them
    always_comb begin
        w_state_next = r_state;
        w_report_ok  = 1'b0;
        w_report_to  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (en) w_state_next = S_TRIG;
            end
            S_TRIG: begin
                if (r_period == TRIG_CYCLES - 1) w_state_next = S_WAIT_RISE;
            end
            S_WAIT_RISE: begin
                if (r_rise) begin
                    w_state_next = S_MEASURE;
                end else if (r_cnt == TIMEOUT_CYCLES - 1) begin
                    w_state_next = S_REPORT;
                    w_report_to  = 1'b1;
                end
            end
            S_MEASURE: begin
                if (r_fall) begin
                    w_state_next = S_REPORT;
                    w_report_ok  = 1'b1;
                end else if (r_cnt == TIMEOUT_CYCLES - 1) begin
                    w_state_next = S_REPORT;
                    w_report_to  = 1'b1;
                end
            end
            S_REPORT: begin
                w_state_next = S_HOLDOFF;
            end
            S_HOLDOFF: begin
                // >= rather than == so an over-long measurement can never strand the FSM here
                if (r_period >= PERIOD_CYCLES - 1) w_state_next = en ? S_TRIG : S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign trig         = (r_state == S_TRIG);
    assign valid        = (r_state == S_REPORT);
    assign timeout      = (r_state == S_REPORT) && r_to;
    assign busy         = (r_state != S_IDLE);
    assign distance_out = r_dist;

    // Period, wait/echo-width timer, per-cm prescaler and the reported distance register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_period <= 32'd0;
            r_cnt    <= 32'd0;
            r_presc  <= 32'd0;
            r_cm     <= '0;
            r_dist   <= '0;
            r_to     <= 1'b0;
        end else begin
            if ((w_state_next == S_TRIG) && (r_state != S_TRIG)) begin
                r_period <= 32'd0;
            end else if (r_state != S_IDLE) begin
                r_period <= r_period + 32'd1;
            end

            if (w_state_next != r_state) begin
                r_cnt <= 32'd0;
            end else if ((r_state == S_WAIT_RISE) || (r_state == S_MEASURE)) begin
                r_cnt <= r_cnt + 32'd1;
            end

            if ((w_state_next == S_MEASURE) && (r_state != S_MEASURE)) begin
                r_presc <= 32'd0;
                r_cm    <= '0;
            end else if (r_state == S_MEASURE) begin
                if (r_presc == CYCLES_PER_CM - 1) begin
                    r_presc <= 32'd0;
                    if (r_cm != CM_MAX) r_cm <= r_cm + DIST_W'(1);
                end else begin
                    r_presc <= r_presc + 32'd1;
                end
            end

            // distance_out changes on the same edge that enters REPORT, so it is fresh while valid is high
            if (w_report_ok) begin
                r_dist <= w_sample;
                r_to   <= 1'b0;
            end else if (w_report_to) begin
                r_dist <= '1;
                r_to   <= 1'b1;
            end
        end
    end

`ifdef ULTRA_SONIC_AVG_EN
    logic [DIST_W-1:0] r_h0;
    logic [DIST_W-1:0] r_h1;
    logic [DIST_W-1:0] r_h2;
    logic              r_h_valid;
    logic [DIST_W+1:0] w_sum;

    // Window is the new sample plus the three previous good ones; before any history, 4x the first sample
    always_comb begin
        w_sum = {r_cm, 2'b00};
        if (r_h_valid) begin
            w_sum = {2'b00, r_cm} + {2'b00, r_h0} + {2'b00, r_h1} + {2'b00, r_h2};
        end
    end

    assign w_sample = DIST_W'(w_sum >> 2);

    // History shift on good samples only; the first sample fills every slot
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_h0      <= '0;
            r_h1      <= '0;
            r_h2      <= '0;
            r_h_valid <= 1'b0;
        end else if (w_report_ok) begin
            r_h_valid <= 1'b1;
            if (!r_h_valid) begin
                r_h0 <= r_cm;
                r_h1 <= r_cm;
                r_h2 <= r_cm;
            end else begin
                r_h0 <= r_cm;
                r_h1 <= r_h0;
                r_h2 <= r_h1;
            end
        end
    end
`else
    assign w_sample = r_cm;
`endif

endmodule

// File: tb/tb_ultra_sonic_ranger.sv
// tb/tb_ultra_sonic_ranger.sv - directed self-checking bench for ultra_sonic_ranger
module tb_ultra_sonic_ranger;

    logic        clk;
    logic        rst;
    logic        en;
    logic        echo;
    logic        trig;
    logic [11:0] distance_out;
    logic        valid;
    logic        timeout;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    ultra_sonic_ranger #(
        .TRIG_CYCLES   (5),
        .PERIOD_CYCLES (2000),
        .TIMEOUT_CYCLES(1000),
        .CYCLES_PER_CM (10),
        .DIST_W        (12)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .echo        (echo),
        .trig        (trig),
        .distance_out(distance_out),
        .valid       (valid),
        .timeout     (timeout),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

`ifdef ULTRA_SONIC_AVG_EN
    localparam logic [11:0] E10 = 12'd10, E20 = 12'd12, E30 = 12'd17, E40 = 12'd25, E40B = 12'd32;
`else
    localparam logic [11:0] E10 = 12'd10, E20 = 12'd20, E30 = 12'd30, E40 = 12'd40, E40B = 12'd40;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_trig_high(input string tag, output int t);
        int k;
        k = 0;
        while (trig !== 1'b1 && k < 2500) begin
            @(negedge clk);
            k++;
        end
        t = cyc;
        check(tag, trig, 1);
    endtask

    task automatic wait_trig_low(input string tag);
        int k;
        k = 0;
        while (trig !== 1'b0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check(tag, trig, 0);
    endtask

    task automatic wait_valid(input string tag, input int budget, output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (valid !== 1'b1 && k < budget);
        check(tag, valid, 1);
    endtask

    // cm < 0: echo never rises (timeout sample)
    task automatic do_sample(input string tag, input int cm, input logic [11:0] exp_d,
                             input logic drop_en, output int t);
        int k;
        wait_trig_high({tag, "_trig"}, t);
        wait_trig_low({tag, "_trig_end"});
        if (cm >= 0) begin
            echo = 1'b1;
            for (int i = 0; i < cm * 10 + 5; i++) begin
                @(negedge clk);
                if (drop_en && i == cm * 5) en = 1'b0;
            end
            echo = 1'b0;
            wait_valid({tag, "_valid"}, 20, k);
            check({tag, "_latency"}, k, 4);
            check({tag, "_to"}, timeout, 0);
        end else begin
            wait_valid({tag, "_valid"}, 1100, k);
            check({tag, "_to"}, timeout, 1);
        end
        check({tag, "_dist"}, distance_out, exp_d);
    endtask

    initial begin
        int n;
        int k;
        int kv;
        int nv;
        int t3, t4, t5, t_last;
        logic to_s;
        logic [11:0] d_s;

        rst  = 1'b0;
        en   = 1'b0;
        echo = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_trig", trig, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", valid, 0);
        check("rst_timeout", timeout, 0);
        check("rst_dist", distance_out, 0);

        // 1: trig pulse width
        rst = 1'b1;
        en  = 1'b1;
        @(negedge clk);
        check("t1_trig_start", trig, 1);
        check("t1_busy", busy, 1);
        n = 1;
        repeat (10) begin
            @(negedge clk);
            if (trig) n++;
        end
        check("t1_trig_width", n, 5);

        // 2: 125 cycles of echo -> 12 cm, strobe 4 edges after fall
        echo = 1'b1;
        repeat (125) @(negedge clk);
        echo = 1'b0;
        wait_valid("t2_valid", 20, k);
        check("t2_latency", k, 4);
        check("t2_dist", distance_out, 12);
        check("t2_to", timeout, 0);
        @(negedge clk);
        check("t2_strobe_1cyc", valid, 0);
        check("t2_dist_hold", distance_out, 12);

        // 3: echo never rises
        wait_trig_high("t3_trig", t3);
        wait_trig_low("t3_trig_end");
        wait_valid("t3_valid", 1500, k);
        check("t3_wait", k, 1000);
        check("t3_to", timeout, 1);
        check("t3_dist", distance_out, 12'hFFF);

        // 4: echo too long
        wait_trig_high("t4_trig", t4);
        check("t4_period", t4 - t3, 2000);
        wait_trig_low("t4_trig_end");
        echo = 1'b1;
        kv = 0;
        nv = 0;
        to_s = 1'b0;
        d_s = '0;
        for (int i = 1; i <= 1500; i++) begin
            @(negedge clk);
            if (valid) begin
                kv = i;
                nv++;
                to_s = timeout;
                d_s = distance_out;
            end
        end
        echo = 1'b0;
        check("t4_when", kv, 1004);
        check("t4_count", nv, 1);
        check("t4_to", to_s, 1);
        check("t4_dist", d_s, 12'hFFF);
        wait_trig_high("t4_next_trig", t5);
        check("t4_next_period", t5 - t4, 2000);

        // 5: reset mid-measurement
        wait_trig_low("t5_trig_end");
        echo = 1'b1;
        repeat (50) @(negedge clk);
        check("t5_busy_before", busy, 1);
        rst = 1'b0;
        @(negedge clk);
        check("t5_trig", trig, 0);
        check("t5_busy", busy, 0);
        check("t5_dist", distance_out, 0);
        check("t5_valid", valid, 0);
        echo = 1'b0;
        nv = 0;
        repeat (5) begin
            @(negedge clk);
            if (valid) nv++;
        end
        rst = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (valid) nv++;
        end
        check("t5_no_strobe", nv, 0);

        // 6: sample sequence, timeout bypass, en drop mid-measurement
        do_sample("s10", 10, E10, 1'b0, t_last);
        do_sample("s20", 20, E20, 1'b0, t_last);
        do_sample("s30", 30, E30, 1'b0, t_last);
        do_sample("s40", 40, E40, 1'b0, t_last);
        do_sample("sto", -1, 12'hFFF, 1'b0, t_last);
        do_sample("s40b", 40, E40B, 1'b1, t_last);
        k = 0;
        while (busy !== 1'b0 && k < 2500) begin
            @(negedge clk);
            k++;
        end
        check("en0_idle", busy, 0);
        check("en0_when", cyc - t_last, 2000);
        check("en0_dist_hold", distance_out, E40B);
        n = 0;
        repeat (100) begin
            @(negedge clk);
            if (trig || busy) n++;
        end
        check("en0_stays_idle", n, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
